// File: rtl/star_pkg.sv
// rtl/star_pkg.sv - shared star-count types and constants
package star_pkg;

  localparam int STAR_MAX = 3;
  localparam int STAR_W   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/star_award_edge_rise.sv
// rtl/star_award_edge_rise.sv - rising-edge detector with sync load
// load resyncs the edge register to the live input and masks rise, so a held level never retriggers.
module edge_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic d,
  output logic rise
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign rise = d & ~q_q & ~load;

endmodule

// File: rtl/star_award.sv
// rtl/star_award.sv - end-of-song grader emitting one spaced pulse per star earned
// Outputs are decoded from registered state only.
module star_award
  import star_pkg::*;
#(
  parameter int          SCORE_W    = 10,
  parameter int unsigned THR1       = 100,
  parameter int unsigned THR2       = 200,
  parameter int unsigned THR3       = 300,
  parameter int unsigned GAP_CYCLES = 25000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               restart,
  input  logic               song_done,
  input  logic [SCORE_W-1:0] score,
  output logic               star_pulse,
  output logic [STAR_W-1:0]  stars_target,
  output logic               busy,
  output logic               award_done
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

  state_e              state_q, state_d;
  logic [STAR_W-1:0]   stars_q, stars_d;
  logic [STAR_W-1:0]   remaining_q, remaining_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic                rise;
  logic [STAR_W-1:0]   target;
  logic [31:0]         score_ext;

  edge_rise u_song_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (restart),
    .d     (song_done),
    .rise  (rise)
  );

  // Thresholds may be unordered, so the grade is simply how many are met.
  always_comb begin
    score_ext = 32'(score);
    target    = STAR_W'(score_ext >= THR1) + STAR_W'(score_ext >= THR2)
              + STAR_W'(score_ext >= THR3);
  end

  always_comb begin
    state_d     = state_q;
    stars_d     = stars_q;
    remaining_d = remaining_q;
    gap_cnt_d   = gap_cnt_q;
    if (restart) begin
      state_d     = IDLE;
      stars_d     = '0;
      remaining_d = '0;
      gap_cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise) begin
            stars_d     = target;
            remaining_d = target;
            state_d     = (target == '0) ? DONE : PULSE;
          end
        end
        PULSE: begin
          remaining_d = remaining_q - STAR_W'(1);
          if (remaining_q <= STAR_W'(1)) begin
            state_d = DONE;
          end else begin
            gap_cnt_d = GAP_LOAD;
            state_d   = GAP;
          end
        end
        GAP: begin
          if (gap_cnt_q == '0) begin
            state_d = PULSE;
          end else begin
            gap_cnt_d = gap_cnt_q - GAP_W'(1);
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      stars_q     <= '0;
      remaining_q <= '0;
      gap_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      stars_q     <= stars_d;
      remaining_q <= remaining_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

  assign star_pulse   = (state_q == PULSE);
  assign award_done   = (state_q == DONE);
  assign busy         = (state_q != IDLE);
  assign stars_target = stars_q;

endmodule

// File: tb/tb_star_award.sv
// tb/tb_star_award.sv - directed self-checking bench for star_award
module tb_star_award;

  logic       clk;
  logic       rst_n;
  logic       restart;
  logic       song_done;
  logic [9:0] score;
  logic       star_pulse;
  logic [1:0] stars_target;
  logic       busy;
  logic       award_done;

  int checks = 0;
  int errors = 0;
  int pulses;
  int dones;

  logic       cnt_clr;
  logic [1:0] star_cnt;

  star_award #(
    .SCORE_W    (10),
    .THR1       (100),
    .THR2       (200),
    .THR3       (300),
    .GAP_CYCLES (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .restart      (restart),
    .song_done    (song_done),
    .score        (score),
    .star_pulse   (star_pulse),
    .stars_target (stars_target),
    .busy         (busy),
    .award_done   (award_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference star counter: +1 on every high cycle, saturating at 3.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        star_cnt <= 2'd0;
    else if (cnt_clr)                  star_cnt <= 2'd0;
    else if (star_pulse && star_cnt != 2'd3) star_cnt <= star_cnt + 2'd1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    restart   = 1'b0;
    song_done = 1'b0;
    score     = 10'd0;
    cnt_clr   = 1'b0;
    #12;
    check("reset_pulse", 32'(star_pulse), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_target", 32'(stars_target), 0);
    check("reset_done", 32'(award_done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // score 250: pulses at k+1 and k+6, award_done at k+7
    score     = 10'd250;
    song_done = 1'b1;
    step();
    for (int c = 1; c <= 7; c++) begin
      check($sformatf("s250_pulse_c%0d", c), 32'(star_pulse), (c == 1 || c == 6) ? 1 : 0);
      check($sformatf("s250_done_c%0d", c), 32'(award_done), (c == 7) ? 1 : 0);
      check($sformatf("s250_busy_c%0d", c), 32'(busy), 1);
      check($sformatf("s250_target_c%0d", c), 32'(stars_target), 2);
      step();
    end
    check("s250_idle_busy", 32'(busy), 0);
    check("s250_target_hold", 32'(stars_target), 2);
    check("s250_counter", 32'(star_cnt), 2);

    // score 50: no stars, award_done immediately
    song_done = 1'b0;
    cnt_clr   = 1'b1;
    step();
    cnt_clr   = 1'b0;
    score     = 10'd50;
    song_done = 1'b1;
    step();
    check("s50_pulse", 32'(star_pulse), 0);
    check("s50_done", 32'(award_done), 1);
    check("s50_target", 32'(stars_target), 0);
    step();
    check("s50_idle", 32'(busy), 0);
    check("s50_counter", 32'(star_cnt), 0);

    // score 1023: three pulses at k+1, k+6, k+11
    song_done = 1'b0;
    step();
    score     = 10'd1023;
    song_done = 1'b1;
    step();
    for (int c = 1; c <= 12; c++) begin
      check($sformatf("s1023_pulse_c%0d", c), 32'(star_pulse),
            (c == 1 || c == 6 || c == 11) ? 1 : 0);
      check($sformatf("s1023_done_c%0d", c), 32'(award_done), (c == 12) ? 1 : 0);
      step();
    end
    check("s1023_target", 32'(stars_target), 3);
    check("s1023_counter", 32'(star_cnt), 3);

    // second song, score 300: three more pulses, counter saturates
    song_done = 1'b0;
    step();
    score     = 10'd300;
    song_done = 1'b1;
    step();
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      if (star_pulse) pulses++;
      step();
    end
    check("s300_pulses", 32'(pulses), 3);
    check("s300_target", 32'(stars_target), 3);
    check("s300_counter_sat", 32'(star_cnt), 3);

    // held high 100 cycles with a glitch rise during GAP
    song_done = 1'b0;
    step();
    score     = 10'd250;
    song_done = 1'b1;
    step();
    pulses = 0;
    dones  = 0;
    for (int c = 1; c <= 100; c++) begin
      if (star_pulse) pulses++;
      if (award_done) dones++;
      if (c == 2) song_done = 1'b0;
      if (c == 3) song_done = 1'b1;
      step();
    end
    check("held_pulses", 32'(pulses), 2);
    check("held_dones", 32'(dones), 1);

    // restart in GAP after first pulse, song_done stays high
    song_done = 1'b0;
    step();
    score     = 10'd350;
    song_done = 1'b1;
    step();
    check("rst_first_pulse", 32'(star_pulse), 1);
    step();
    check("rst_in_gap", 32'(busy), 1);
    restart = 1'b1;
    step();
    restart = 1'b0;
    check("rst_busy", 32'(busy), 0);
    check("rst_target", 32'(stars_target), 0);
    pulses = 0;
    dones  = 0;
    for (int c = 0; c < 30; c++) begin
      if (star_pulse) pulses++;
      if (award_done) dones++;
      if (busy) dones++;
      step();
    end
    check("rst_no_pulse", 32'(pulses), 0);
    check("rst_no_done_busy", 32'(dones), 0);

    // asynchronous reset in the middle of a PULSE cycle
    song_done = 1'b0;
    step();
    score     = 10'd1023;
    song_done = 1'b1;
    step();
    #2;
    check("arst_pre_pulse", 32'(star_pulse), 1);
    rst_n = 1'b0;
    #1;
    check("arst_pulse", 32'(star_pulse), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_target", 32'(stars_target), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
